// File: rtl/freq_display_ctrl.sv
// Frequency display sequencer: binary count -> 8-digit BCD (shift-add-3),
// auto-ranged to a 4-digit window with exponent and leading-zero blanking.
module freq_display_ctrl #(
    parameter int         BIN_W      = 24,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       in0,
    output logic [3:0]       in1,
    output logic [3:0]       in2,
    output logic [3:0]       in3,
    output logic [2:0]       exp
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, SELECT} state_t;

    state_t           state_q;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [31:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q;
    logic [BIN_W-1:0] pend_q;
    logic             pend_v_q;
    logic             busy_q, done_q;
    logic [15:0]      disp_q;
    logic [2:0]       exp_q;

    // Window selection results, computed from the finished BCD value
    logic [2:0]  k;
    logic [31:0] shifted;
    logic [15:0] win_d;
    logic [2:0]  exp_d;
    logic [31:0] bcd_adj;

    // One double-dabble step: correct nibbles >= 5, then shift {bcd,shift} left
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d   = {bcd_adj[30:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
    end

    // Auto-range: keep the four most significant digits, blank leading zeros
    always_comb begin
        k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0)
                k = 3'(i);
        end
        exp_d   = 3'd0;
        shifted = bcd_q;
        if (k >= 3'd4) begin
            exp_d   = k - 3'd3;
            shifted = bcd_q >> (4 * exp_d);
        end
        win_d = shifted[15:0];
        // Blanking only happens in the unscaled window; digit 0 always shows
        if (k < 3'd4) begin
            for (int j = 1; j < 4; j++) begin
                if (3'(j) > k)
                    win_d[4*j +: 4] = BLANK_CODE;
            end
        end
    end

    // Sequencer FSM with registered outputs and one-deep pending buffer
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            disp_q   <= {BLANK_CODE, BLANK_CODE, BLANK_CODE, 4'h0};
            exp_q    <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q <= value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_q   <= bcd_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1))
                        state_q <= SELECT;
                    // A result arriving mid-conversion waits here; latest wins
                    if (load) begin
                        pend_q   <= value;
                        pend_v_q <= 1'b1;
                    end
                end
                SELECT: begin
                    disp_q <= win_d;
                    exp_q  <= exp_d;
                    done_q <= 1'b1;
                    if (load || pend_v_q) begin
                        // A fresh load supersedes anything still pending
                        shift_q  <= load ? value : pend_q;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        pend_v_q <= 1'b0;
                        state_q  <= CONVERT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign in0  = disp_q[3:0];
    assign in1  = disp_q[7:4];
    assign in2  = disp_q[11:8];
    assign in3  = disp_q[15:12];
    assign exp  = exp_q;

endmodule

// File: tb/tb_freq_display_ctrl.sv
// Directed bench for freq_display_ctrl: ranging, blanking, pending buffer, reset abort.
module tb_freq_display_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic [23:0] value = '0;
    logic        busy, done;
    logic [3:0]  in0, in1, in2, in3;
    logic [2:0]  exp;

    int vectors = 0;
    int errs    = 0;
    int n;
    int pulses;

    freq_display_ctrl #(.BIN_W(24), .BLANK_CODE(4'hF)) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .busy(busy), .done(done),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .exp(exp)
    );

    always #5 clock = ~clock;

    wire [18:0] disp = {in3, in2, in1, in0, exp};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Pulse load for one edge (that edge is E0)
    task automatic do_load(input logic [23:0] v);
        load  = 1'b1;
        value = v;
        tick();
        load  = 1'b0;
    endtask

    // Count edges until done is seen, bounded
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!done && cnt < 60);
    endtask

    task automatic conv(input string tag, input logic [23:0] v, input logic [18:0] expd);
        int c;
        do_load(v);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(c);
        chk({tag, "_lat"}, 32'(c), 32'd25);
        chk({tag, "_disp"}, 32'(disp), 32'(expd));
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        // 1: reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_disp", 32'(disp), 32'({4'hF, 4'hF, 4'hF, 4'h0, 3'd0}));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // 2..4: single conversions
        conv("v0",        24'd0,        {4'hF, 4'hF, 4'hF, 4'h0, 3'd0});
        conv("v105",      24'd105,      {4'hF, 4'h1, 4'h0, 4'h5, 3'd0});
        conv("v4999",     24'd4999,     {4'h4, 4'h9, 4'h9, 4'h9, 3'd0});
        conv("v9",        24'd9,        {4'hF, 4'hF, 4'hF, 4'h9, 3'd0});
        conv("v49999",    24'd49999,    {4'h4, 4'h9, 4'h9, 4'h9, 3'd1});
        conv("v1000000",  24'd1000000,  {4'h1, 4'h0, 4'h0, 4'h0, 3'd3});
        conv("v16777215", 24'd16777215, {4'h1, 4'h6, 4'h7, 4'h7, 3'd4});

        // 5: pending buffer, latest wins
        do_load(24'd1234);           // E0
        repeat (4) tick();
        do_load(24'd555);            // E5
        repeat (4) tick();
        do_load(24'd777);            // E10
        wait_done(n);
        chk("pend_lat1", 32'(n), 32'd15);
        chk("pend_disp1", 32'(disp), 32'({4'h1, 4'h2, 4'h3, 4'h4, 3'd0}));
        chk("pend_busy1", 32'(busy), 32'd1);
        wait_done(n);
        chk("pend_lat2", 32'(n), 32'd25);
        chk("pend_disp2", 32'(disp), 32'({4'hF, 4'h7, 4'h7, 4'h7, 3'd0}));
        tick();
        chk("pend_idle", {30'd0, busy, done}, 32'd0);

        // 6: reset mid-conversion aborts without done
        do_load(24'd4999);           // E0
        repeat (11) tick();
        reset = 1'b1;
        tick();                      // E12
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_disp", 32'(disp), 32'({4'hF, 4'hF, 4'hF, 4'h0, 3'd0}));
        pulses = 0;
        repeat (20) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_nodone", 32'(pulses), 32'd0);
        conv("v42", 24'd42, {4'hF, 4'hF, 4'h4, 4'h2, 3'd0});

        // load coincident with reset: reset wins
        reset = 1'b1;
        do_load(24'd123);
        reset = 1'b0;
        chk("rst_vs_load", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/freq_display_ctrl.md
Name: freq_display_ctrl

Overview:
Sequencing controller between the frequency-counter result and the four-digit Seven_seg driver. It accepts a binary count and converts it to eight BCD digits with a sequential shift-add-3 (double-dabble) engine. It then auto-ranges to the four most significant digits, applies leading-zero blanking and drives in0..in3 plus a range exponent. A one-deep pending buffer absorbs a result that arrives while a conversion is in progress.

Parameters:
BIN_W, 24, width of binary input; fixed 8-digit BCD result (valid for BIN_W <= 26)
BLANK_CODE, 4'hF, digit code Seven_seg renders as all segments off

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
load  in  1  one-cycle strobe, value valid
value  in  BIN_W  binary count to display
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when in0..in3/exp update
in0  out  4  rightmost digit to Seven_seg
in1  out  4  digit 1
in2  out  4  digit 2
in3  out  4  leftmost digit
exp  out  3  decimal exponent of window: displayed = value / 10^exp (0..4)

Behaviour:
- States: IDLE, CONVERT, SELECT. Registered outputs only.
- Reset values (any state, including mid-CONVERT): state=IDLE, busy=0, done=0, pending cleared, in3=in2=in1=BLANK_CODE, in0=0, exp=0. Reset mid-conversion aborts it with no done pulse.
- IDLE: at edge E0 with load=1: latch value into shift reg, BCD reg=0, bit counter=0, go to CONVERT; busy=1 from after E0.
- CONVERT: on each edge E1..E(BIN_W):
  - first add 3 to every BCD nibble >= 5;
  - then shift {bcd,shift} left 1.
  - After E(BIN_W), go to SELECT.
- SELECT: one edge E(BIN_W+1) registers the outputs and sets done=1 for exactly one cycle. Latency load edge -> outputs valid = BIN_W+1 cycles (25 at default).
- Window select on BCD digits d7..d0:
  - k = index of most significant non-zero digit (k=0 if value=0).
  - k<=3: in3..in0 = d3..d0, exp=0.
  - k>=4: in3..in0 = d(k)..d(k-3), exp=k-3. Truncation, no rounding.
- Blanking, applied only when exp=0: digits at positions >k become BLANK_CODE. in0 is never blanked.
- Pending buffer:
  - load=1 while busy=1: store value in pending reg and set pending_v. A later load overwrites it (latest wins).
  - At the SELECT edge: if load=1 that cycle, start that value; else if pending_v, start pending value and clear pending_v. Either way go straight to CONVERT, busy stays 1, done still pulses.
  - Otherwise go to IDLE, busy=0.
- load in IDLE on the same edge as reset: reset wins.
- Outputs hold their last values between done pulses.

Test Plan:
1. Hold reset 3 cycles -> in3..in0 = F,F,F,0; exp=0; busy=0; done=0.
2. load value=0 at E0 -> busy=1 for E0..E24; done pulses after E25; outputs F,F,F,0, exp=0.
3. load 105 -> F,1,0,5, exp=0. Then load 4999 -> 4,9,9,9, exp=0. Then load 9 -> F,F,F,9.
4. load 49999 -> 4,9,9,9, exp=1. load 1000000 -> 1,0,0,0, exp=3. load 16777215 -> 1,6,7,7, exp=4.
5. load 1234 at E0; load 555 at E5; load 777 at E10 -> done after E25 showing 1,2,3,4. busy stays 1, conversion of 777 runs, second done 25 cycles later showing F,7,7,7. 555 is never displayed.
6. load 4999; assert reset at E12 for 1 cycle -> next cycle busy=0, outputs F,F,F,0, no done pulse. A subsequent load of 42 -> F,F,4,2 after 25 cycles.
